bus_arbiter: RTL

Round-robin arbiter sharing the serial bus between MASTERS requesters. It sits in the interconnect ahead of the slave ports and grants exclusive ownership to one master at a time. Its select output steers control/wD/valid/last toward the slaves and rD/ready back. A one-cycle idle gap after every release keeps `control` low between owners, so a slave returns to IDLE before the next start sequence.

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus arbiter and the interconnect mux that
// follows its owner select.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int MASTERS_DEF    = 2;
    localparam int M_ID_WIDTH_DEF = $clog2(MASTERS_DEF);

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or above last_owner+1,
// wrapping around, so the most recent owner always ranks last.
module rr_picker
    import bus_pkg::*;
#(
    parameter int MASTERS    = MASTERS_DEF,
    parameter int M_ID_WIDTH = $clog2(MASTERS)
) (
    input  logic [MASTERS-1:0]    req,
    input  logic [M_ID_WIDTH-1:0] last_owner,
    output logic                  valid,
    output logic [M_ID_WIDTH-1:0] winner
);

    // Scan from the far end down so the nearest rotated candidate is written last.
    always_comb begin
        int idx;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            idx = (int'(last_owner) + 1 + i) % MASTERS;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = M_ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared serial bus, with a one-cycle idle gap
// after every release. Optional forced release after TIMEOUT cycles: ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MASTERS    = MASTERS_DEF,
    parameter int M_ID_WIDTH = $clog2(MASTERS),
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MASTERS-1:0]    req,
    output logic [MASTERS-1:0]    grant,
    output logic [M_ID_WIDTH-1:0] owner,
    output logic                  busy,
    output logic                  timeout
);

    arb_state_t            state;
    logic [M_ID_WIDTH-1:0] last_owner;
    logic                  pick_valid;
    logic [M_ID_WIDTH-1:0] pick_winner;

    rr_picker #(
        .MASTERS    (MASTERS),
        .M_ID_WIDTH (M_ID_WIDTH)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            last_owner <= M_ID_WIDTH'(MASTERS - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant              <= '0;
                        grant[pick_winner] <= 1'b1;
                        owner              <= pick_winner;
                        last_owner         <= pick_winner;
                        busy               <= 1'b1;
                        state              <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt           <= '0;
`endif
                    end
                end
                GRANT: begin
                    // No preemption: only the owner's own req (or the hold limit) ends tenure.
                    if (!req[owner]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= GAP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == CNT_W'(TIMEOUT - 1)) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
